// File: rtl/cpu_defs_pkg.sv
// Shared CPU encodings: load types, write-back FSM states and datapath defaults.
package cpu_defs;

   localparam int WIDTH_DEF  = 32;
   localparam int ADDR_W_DEF = 5;

   typedef enum logic [2:0] {
      LD_NONE = 3'd0,
      LD_LB   = 3'd1,
      LD_LBU  = 3'd2,
      LD_LH   = 3'd3,
      LD_LHU  = 3'd4,
      LD_LW   = 3'd5,
      LD_LWL  = 3'd6,
      LD_LWR  = 3'd7
   } load_type_t;

   typedef enum logic [1:0] {
      ST_EMPTY     = 2'd0,
      ST_WAIT_LOAD = 2'd1,
      ST_COMMIT    = 2'd2,
      ST_DRAIN     = 2'd3
   } wb_state_t;

   function automatic logic is_load(input logic [2:0] load_type);
      return load_type != LD_NONE;
   endfunction

endpackage

// File: rtl/load_align.sv
// Little-endian load extraction: byte/halfword extension and LWL/LWR merge with old rt.
// Purely combinational; misaligned accesses are assumed already excepted.
module load_align
   import cpu_defs::*;
(
   input  logic [2:0]  load_type,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] rdata,
   input  logic [31:0] rt_old,
   output logic [31:0] result
);

   logic [7:0]  b0, b1, b2, b3;
   logic [7:0]  bsel;
   logic [15:0] hsel;

   assign b0 = rdata[7:0];
   assign b1 = rdata[15:8];
   assign b2 = rdata[23:16];
   assign b3 = rdata[31:24];

   always_comb begin
      bsel = b0;
      case (addr_lo)
         2'd0: bsel = b0;
         2'd1: bsel = b1;
         2'd2: bsel = b2;
         2'd3: bsel = b3;
         default: bsel = b0;
      endcase
      hsel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
   end

   always_comb begin
      result = rdata;
      case (load_type_t'(load_type))
         LD_LB:  result = {{24{bsel[7]}}, bsel};
         LD_LBU: result = {24'd0, bsel};
         LD_LH:  result = {{16{hsel[15]}}, hsel};
         LD_LHU: result = {16'd0, hsel};
         LD_LW:  result = rdata;
         LD_LWL: begin
            case (addr_lo)
               2'd0: result = {b0, rt_old[23:0]};
               2'd1: result = {b1, b0, rt_old[15:0]};
               2'd2: result = {b2, b1, b0, rt_old[7:0]};
               default: result = rdata;
            endcase
         end
         LD_LWR: begin
            case (addr_lo)
               2'd1: result = {rt_old[31:24], b3, b2, b1};
               2'd2: result = {rt_old[31:16], b3, b2};
               2'd3: result = {rt_old[31:8], b3};
               default: result = rdata;
            endcase
         end
         default: result = rdata;
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// MIPS write-back stage: holds the retiring instruction, waits for load data, drives the RF write port.
// Trace outputs are live only when WB_DEBUG_TRACE_EN is defined; otherwise they are tied to zero.
module wb_stage
   import cpu_defs::*;
#(
   parameter int WIDTH  = WIDTH_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mem_valid,
   input  logic [31:0]       mem_pc,
   input  logic              mem_reg_write,
   input  logic [ADDR_W-1:0] mem_dst,
   input  logic [WIDTH-1:0]  mem_result,
   input  logic [2:0]        mem_load_type,
   input  logic [1:0]        mem_addr_lo,
   input  logic [WIDTH-1:0]  mem_rt_old,
   input  logic              dc_rdata_valid,
   input  logic [WIDTH-1:0]  dc_rdata,
   input  logic              wb_flush,
   output logic              wb_stall,
   output logic              reg_write,
   output logic [ADDR_W-1:0] write_register,
   output logic [WIDTH-1:0]  write_data,
   output logic [31:0]       debug_wb_pc,
   output logic [3:0]        debug_wb_rf_wen,
   output logic [4:0]        debug_wb_rf_wnum,
   output logic [31:0]       debug_wb_rf_wdata
);

   wb_state_t state, state_nxt;

   logic              capture;
   logic              rw_h;
   logic [ADDR_W-1:0] dst_h;
   logic [2:0]        lt_h;
   logic [1:0]        lo_h;
   logic [WIDTH-1:0]  rt_h;

   logic [2:0]        al_type;
   logic [1:0]        al_lo;
   logic [WIDTH-1:0]  al_rt;
   logic [WIDTH-1:0]  aligned;

   logic              commit_rw;
   logic [ADDR_W-1:0] commit_dst;
   logic [WIDTH-1:0]  commit_data;
   logic              commit_we;
   logic              entering_commit;

   assign wb_stall = (state == ST_WAIT_LOAD) || (state == ST_DRAIN);
   assign capture  = mem_valid && !wb_stall && !wb_flush;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= ST_EMPTY;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_EMPTY, ST_COMMIT: begin
            if (capture)
               state_nxt = (!is_load(mem_load_type) || dc_rdata_valid) ? ST_COMMIT : ST_WAIT_LOAD;
            else
               state_nxt = ST_EMPTY;
         end
         ST_WAIT_LOAD: begin
            // A flushed load still owns its response; DRAIN swallows it if it hasn't arrived.
            if (dc_rdata_valid)  state_nxt = wb_flush ? ST_EMPTY : ST_COMMIT;
            else if (wb_flush)   state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (dc_rdata_valid)  state_nxt = ST_EMPTY;
         end
         default: state_nxt = ST_EMPTY;
      endcase
   end

   // While stalled the committing instruction is the held one; otherwise it is the one being captured.
   always_comb begin
      al_type     = wb_stall ? lt_h  : mem_load_type;
      al_lo       = wb_stall ? lo_h  : mem_addr_lo;
      al_rt       = wb_stall ? rt_h  : mem_rt_old;
      commit_rw   = wb_stall ? rw_h  : mem_reg_write;
      commit_dst  = wb_stall ? dst_h : mem_dst;
      commit_data = is_load(al_type) ? aligned : mem_result;
      entering_commit = (state_nxt == ST_COMMIT);
      commit_we   = entering_commit && commit_rw && (commit_dst != '0);
   end

   load_align u_load_align (
      .load_type (al_type),
      .addr_lo   (al_lo),
      .rdata     (dc_rdata),
      .rt_old    (al_rt),
      .result    (aligned)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rw_h  <= 1'b0;
         dst_h <= '0;
         lt_h  <= '0;
         lo_h  <= '0;
         rt_h  <= '0;
      end else if (capture) begin
         rw_h  <= mem_reg_write;
         dst_h <= mem_dst;
         lt_h  <= mem_load_type;
         lo_h  <= mem_addr_lo;
         rt_h  <= mem_rt_old;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         reg_write      <= 1'b0;
         write_register <= '0;
         write_data     <= '0;
      end else begin
         reg_write      <= commit_we;
         write_register <= entering_commit ? commit_dst  : '0;
         write_data     <= entering_commit ? commit_data : '0;
      end
   end

`ifdef WB_DEBUG_TRACE_EN
   logic [31:0] pc_h;
   logic [31:0] commit_pc;

   assign commit_pc = wb_stall ? pc_h : mem_pc;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_h              <= '0;
         debug_wb_pc       <= '0;
         debug_wb_rf_wen   <= '0;
         debug_wb_rf_wnum  <= '0;
         debug_wb_rf_wdata <= '0;
      end else begin
         if (capture) pc_h <= mem_pc;
         debug_wb_pc       <= entering_commit ? commit_pc : '0;
         debug_wb_rf_wen   <= {4{commit_we}};
         debug_wb_rf_wnum  <= entering_commit ? commit_dst  : '0;
         debug_wb_rf_wdata <= entering_commit ? commit_data : '0;
      end
   end
`else
   logic unused_pc;

   assign unused_pc         = ^mem_pc;
   assign debug_wb_pc       = '0;
   assign debug_wb_rf_wen   = '0;
   assign debug_wb_rf_wnum  = '0;
   assign debug_wb_rf_wdata = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: stimulus pushes expected RF writes, a negedge monitor pops and compares.
module tb_wb_stage;
   import cpu_defs::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_valid;
   logic [31:0] mem_pc;
   logic        mem_reg_write;
   logic [4:0]  mem_dst;
   logic [31:0] mem_result;
   logic [2:0]  mem_load_type;
   logic [1:0]  mem_addr_lo;
   logic [31:0] mem_rt_old;
   logic        dc_rdata_valid;
   logic [31:0] dc_rdata;
   logic        wb_flush;
   logic        wb_stall;
   logic        reg_write;
   logic [4:0]  write_register;
   logic [31:0] write_data;
   logic [31:0] debug_wb_pc;
   logic [3:0]  debug_wb_rf_wen;
   logic [4:0]  debug_wb_rf_wnum;
   logic [31:0] debug_wb_rf_wdata;

   wb_stage dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .mem_valid         (mem_valid),
      .mem_pc            (mem_pc),
      .mem_reg_write     (mem_reg_write),
      .mem_dst           (mem_dst),
      .mem_result        (mem_result),
      .mem_load_type     (mem_load_type),
      .mem_addr_lo       (mem_addr_lo),
      .mem_rt_old        (mem_rt_old),
      .dc_rdata_valid    (dc_rdata_valid),
      .dc_rdata          (dc_rdata),
      .wb_flush          (wb_flush),
      .wb_stall          (wb_stall),
      .reg_write         (reg_write),
      .write_register    (write_register),
      .write_data        (write_data),
      .debug_wb_pc       (debug_wb_pc),
      .debug_wb_rf_wen   (debug_wb_rf_wen),
      .debug_wb_rf_wnum  (debug_wb_rf_wnum),
      .debug_wb_rf_wdata (debug_wb_rf_wdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      logic [4:0]  dst;
      logic [31:0] data;
      logic [31:0] pc;
   } exp_t;

   exp_t exp_q[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   logic mon_en = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_wr(input logic [4:0] dst, input logic [31:0] data, input logic [31:0] pc);
      exp_t e;
      e.cyc  = cyc + 1;
      e.dst  = dst;
      e.data = data;
      e.pc   = pc;
      exp_q.push_back(e);
   endtask

   task automatic mem_op(input logic [31:0] pc, input logic [4:0] dst, input logic [31:0] res,
                         input logic [2:0] lt, input logic [1:0] lo, input logic [31:0] rt);
      mem_valid     = 1'b1;
      mem_pc        = pc;
      mem_reg_write = 1'b1;
      mem_dst       = dst;
      mem_result    = res;
      mem_load_type = lt;
      mem_addr_lo   = lo;
      mem_rt_old    = rt;
   endtask

   task automatic nonload(input logic [31:0] pc, input logic [4:0] dst, input logic [31:0] res);
      mem_op(pc, dst, res, LD_NONE, 2'd0, 32'h0);
      if (dst != 5'd0) expect_wr(dst, res, pc);
      tick();
      mem_valid = 1'b0;
      chk("nonload_stall", {31'd0, wb_stall}, 32'd0);
   endtask

   // Load whose response arrives nwait cycles after the capture edge.
   task automatic load_wait(input logic [31:0] pc, input logic [4:0] dst, input logic [2:0] lt,
                            input logic [1:0] lo, input logic [31:0] rt, input logic [31:0] data,
                            input logic [31:0] exp, input int nwait);
      mem_op(pc, dst, 32'h0, lt, lo, rt);
      tick();
      mem_valid = 1'b0;
      for (int i = 0; i < nwait; i++) begin
         chk("load_wait_stall", {31'd0, wb_stall}, 32'd1);
         if (i == nwait - 1) begin
            dc_rdata_valid = 1'b1;
            dc_rdata       = data;
            expect_wr(dst, exp, pc);
         end
         tick();
      end
      dc_rdata_valid = 1'b0;
      chk("load_commit_stall", {31'd0, wb_stall}, 32'd0);
   endtask

   task automatic load_now(input logic [31:0] pc, input logic [4:0] dst, input logic [2:0] lt,
                           input logic [1:0] lo, input logic [31:0] rt, input logic [31:0] data,
                           input logic [31:0] exp);
      mem_op(pc, dst, 32'h0, lt, lo, rt);
      dc_rdata_valid = 1'b1;
      dc_rdata       = data;
      expect_wr(dst, exp, pc);
      tick();
      mem_valid      = 1'b0;
      dc_rdata_valid = 1'b0;
      chk("load_now_stall", {31'd0, wb_stall}, 32'd0);
   endtask

   always @(negedge clk) begin
      if (mon_en && reg_write === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write: reg=%0d data=0x%08h, expected no write (cycle %0d)",
                     write_register, write_data, cyc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("wb_dst", {27'd0, write_register}, {27'd0, e.dst});
            chk("wb_data", write_data, e.data);
            chk("wb_cycle", cyc, e.cyc);
`ifdef WB_DEBUG_TRACE_EN
            chk("dbg_pc", debug_wb_pc, e.pc);
            chk("dbg_wen", {28'd0, debug_wb_rf_wen}, 32'hF);
            chk("dbg_wnum", {27'd0, debug_wb_rf_wnum}, {27'd0, e.dst});
            chk("dbg_wdata", debug_wb_rf_wdata, e.data);
`else
            chk("dbg_pc_tied", debug_wb_pc, 32'h0);
            chk("dbg_wen_tied", {28'd0, debug_wb_rf_wen}, 32'h0);
`endif
         end
      end
   end

   initial begin
      rst_n          = 1'b0;
      mem_valid      = 1'b0;
      mem_pc         = '0;
      mem_reg_write  = 1'b0;
      mem_dst        = '0;
      mem_result     = '0;
      mem_load_type  = '0;
      mem_addr_lo    = '0;
      mem_rt_old     = '0;
      dc_rdata_valid = 1'b0;
      dc_rdata       = '0;
      wb_flush       = 1'b0;

      repeat (3) tick();
      chk("rst_reg_write", {31'd0, reg_write}, 32'd0);
      chk("rst_wreg", {27'd0, write_register}, 32'd0);
      chk("rst_wdata", write_data, 32'd0);
      chk("rst_stall", {31'd0, wb_stall}, 32'd0);
      chk("rst_dbg_pc", debug_wb_pc, 32'd0);
      chk("rst_dbg_wen", {28'd0, debug_wb_rf_wen}, 32'd0);
      rst_n  = 1'b1;
      mon_en = 1'b1;
      tick();

      // Back-to-back ALU results; $0 must not be written.
      nonload(32'h0000_0100, 5'd3, 32'h11);
      nonload(32'h0000_0104, 5'd4, 32'h22);
      nonload(32'h0000_0108, 5'd0, 32'h33);
      tick();

      // Byte/halfword loads.
      load_wait(32'h0000_0200, 5'd8,  LD_LB,  2'd2, 32'h0, 32'h80FF1234, 32'hFFFFFFFF, 3);
      load_now (32'h0000_0204, 5'd9,  LD_LBU, 2'd2, 32'h0, 32'h80FF1234, 32'h000000FF);
      load_now (32'h0000_0208, 5'd10, LD_LH,  2'd2, 32'h0, 32'h80FF1234, 32'hFFFF80FF);
      load_now (32'h0000_020C, 5'd11, LD_LHU, 2'd2, 32'h0, 32'h80FF1234, 32'h000080FF);
      load_now (32'h0000_0210, 5'd12, LD_LB,  2'd0, 32'h0, 32'h80FF1234, 32'h00000034);

      // Unaligned word merges.
      load_wait(32'h0000_0300, 5'd13, LD_LWL, 2'd1, 32'hAABBCCDD, 32'h11223344, 32'h3344CCDD, 1);
      load_wait(32'h0000_0304, 5'd14, LD_LWR, 2'd1, 32'hAABBCCDD, 32'h11223344, 32'hAA112233, 2);
      load_now (32'h0000_0308, 5'd15, LD_LWL, 2'd3, 32'hAABBCCDD, 32'h11223344, 32'h11223344);
      load_now (32'h0000_030C, 5'd16, LD_LWR, 2'd0, 32'hAABBCCDD, 32'h11223344, 32'h11223344);
      load_now (32'h0000_0310, 5'd17, LD_LWL, 2'd0, 32'hAABBCCDD, 32'h11223344, 32'h44BBCCDD);
      load_now (32'h0000_0314, 5'd18, LD_LWR, 2'd3, 32'hAABBCCDD, 32'h11223344, 32'hAABBCC11);

      // Same-cycle word load followed immediately by an ALU op.
      load_now (32'h0000_0400, 5'd19, LD_LW, 2'd0, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF);
      nonload  (32'h0000_0404, 5'd20, 32'h0000_00A5);
      tick();

      // Flush in WAIT_LOAD, response two cycles later is drained.
      mem_op(32'h0000_0500, 5'd7, 32'h0, LD_LW, 2'd0, 32'h0);
      tick();
      mem_valid = 1'b0;
      chk("flush_wait_stall", {31'd0, wb_stall}, 32'd1);
      wb_flush = 1'b1;
      tick();
      wb_flush = 1'b0;
      chk("drain_stall0", {31'd0, wb_stall}, 32'd1);
      tick();
      chk("drain_stall1", {31'd0, wb_stall}, 32'd1);
      dc_rdata_valid = 1'b1;
      dc_rdata       = 32'h9999_9999;
      tick();
      dc_rdata_valid = 1'b0;
      chk("drain_done_stall", {31'd0, wb_stall}, 32'd0);
      nonload(32'h0000_0504, 5'd5, 32'h55);

      // Flush arriving together with the response: no write, no drain.
      mem_op(32'h0000_0600, 5'd21, 32'h0, LD_LW, 2'd0, 32'h0);
      tick();
      mem_valid      = 1'b0;
      wb_flush       = 1'b1;
      dc_rdata_valid = 1'b1;
      dc_rdata       = 32'h1234_5678;
      tick();
      wb_flush       = 1'b0;
      dc_rdata_valid = 1'b0;
      chk("flush_with_data_stall", {31'd0, wb_stall}, 32'd0);

      // Flush on the capture cycle blocks capture.
      mem_op(32'h0000_0700, 5'd22, 32'h77, LD_NONE, 2'd0, 32'h0);
      wb_flush = 1'b1;
      tick();
      mem_valid = 1'b0;
      wb_flush  = 1'b0;
      chk("flush_capture_stall", {31'd0, wb_stall}, 32'd0);
      tick();

      // Reset while waiting for a load.
      mem_op(32'h0000_0800, 5'd9, 32'h0, LD_LW, 2'd0, 32'h0);
      tick();
      mem_valid = 1'b0;
      chk("pre_rst_stall", {31'd0, wb_stall}, 32'd1);
      rst_n = 1'b0;
      tick();
      chk("rst_wait_stall", {31'd0, wb_stall}, 32'd0);
      chk("rst_wait_reg_write", {31'd0, reg_write}, 32'd0);
      chk("rst_wait_wreg", {27'd0, write_register}, 32'd0);
      chk("rst_wait_wdata", write_data, 32'd0);
      rst_n          = 1'b1;
      dc_rdata_valid = 1'b1;
      dc_rdata       = 32'hCAFE_F00D;
      tick();
      dc_rdata_valid = 1'b0;
      chk("stray_data_stall", {31'd0, wb_stall}, 32'd0);
      nonload(32'h0000_0804, 5'd6, 32'h66);

      repeat (3) tick();
      chk("scoreboard_drained", exp_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_stage.md
# wb_stage

Write-back stage of the 5-stage MIPS pipeline, sitting between the MEM stage and the ID-stage register file write port. It registers the retiring instruction, waits for outstanding data-cache load data, and performs byte/halfword/LWL/LWR extraction and merging. It then drives the register file's one-cycle write strobe, destination and data. It stalls the pipeline while a load response is pending.

## Interface
Parameters:
- WIDTH, 32, datapath width
- ADDR_W, 5, register number width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- mem_valid  in  1  MEM stage presents an instruction this cycle
- mem_pc  in  32  PC of presented instruction
- mem_reg_write  in  1  instruction writes a GPR
- mem_dst  in  ADDR_W  destination register
- mem_result  in  WIDTH  ALU/move result (non-load)
- mem_load_type  in  3  0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 LWL, 7 LWR
- mem_addr_lo  in  2  load address bits [1:0]
- mem_rt_old  in  WIDTH  old rt value for LWL/LWR merge
- dc_rdata_valid  in  1  data-cache load data valid (one pulse per load)
- dc_rdata  in  WIDTH  aligned word from data cache
- wb_flush  in  1  kill instruction being captured / held
- wb_stall  out  1  WB cannot accept; MEM must hold
- reg_write  out  1  register file write strobe
- write_register  out  ADDR_W  write destination
- write_data  out  WIDTH  write data
- debug_wb_pc  out  32  retiring PC (trace)
- debug_wb_rf_wen  out  4  trace write enables
- debug_wb_rf_wnum  out  5  trace register
- debug_wb_rf_wdata  out  32  trace data

## Operation
- States: EMPTY, WAIT_LOAD, COMMIT, DRAIN.
- Capture occurs when mem_valid && !wb_stall && !wb_flush. Non-load goes to COMMIT. A load with dc_rdata_valid in the same cycle goes to COMMIT with aligned data. A load without it goes to WAIT_LOAD.
- No capture: EMPTY/COMMIT go to EMPTY.
- WAIT_LOAD: dc_rdata_valid goes to COMMIT with aligned data. wb_flush without data goes to DRAIN. wb_flush together with data goes to EMPTY (no write).
- DRAIN: waits for dc_rdata_valid, then goes to EMPTY. The data is discarded. The AXI response is always consumed.
- wb_stall = (state == WAIT_LOAD) || (state == DRAIN).
- reg_write = (state == COMMIT) && held reg_write && held dst != 0.
- dc_rdata_valid in EMPTY or COMMIT with no load captured: ignored.
- Alignment is little-endian, b_n = byte n of dc_rdata.
  - LB/LBU: sign/zero extend byte addr_lo.
  - LH/LHU: halfword addr_lo[1].
  - LW: word.
  - LWL: lo=0 {b0, rt[23:0]}; 1 {b1,b0, rt[15:0]}; 2 {b2,b1,b0, rt[7:0]}; 3 word.
  - LWR: lo=0 word; 1 {rt[31:24], b3..b1}; 2 {rt[31:16], b3,b2}; 3 {rt[31:8], b3}.
- Misaligned addresses are excepted upstream and never reach this block.

## Timing
- Reset: state EMPTY, every output 0, held registers 0.
- Reset in WAIT_LOAD or DRAIN goes to EMPTY; the memory side is reset simultaneously.
- Non-load: capture at edge N, reg_write high during cycle N+1. Full throughput, one per cycle.
- Load: reg_write is high the cycle after the edge that samples dc_rdata_valid. The first cycle with wb_stall low is the COMMIT cycle.
- reg_write is a single-cycle pulse per committed instruction. The register file writes at the same edge and bypasses the value to ID reads in that cycle.
- All outputs are registered, except wb_stall, which is a decode of the state register.

## Configuration
- WB_DEBUG_TRACE_EN defined: debug_wb_* are driven during COMMIT.
  - debug_wb_pc = held PC.
  - debug_wb_rf_wen = {4{reg_write}}.
  - wnum/wdata mirror write_register/write_data.
- Undefined: debug ports exist but are tied to 0. The held PC register is removed.

## Structure
- Shared package cpu_defs holds the load-type encodings (LD_NONE..LD_LWR), the wb state encoding and WIDTH defaults.
- One combinational sub-module, load_align, maps (load_type, addr_lo, rdata, rt_old) to aligned result. It is instantiated once, on the dc_rdata path.

## Test plan
- Back-to-back non-loads $3=0x11, $4=0x22, $0=0x33: reg_write pulses on consecutive cycles. No write for $0. wb_stall stays 0.
- LB from addr_lo=2, data 0x80FF1234, response 3 cycles later: wb_stall high 3 cycles, then write 0xFFFFFFFF. LBU gives 0x000000FF.
- LWL lo=1, rt_old 0xAABBCCDD, data 0x11223344: write 0x3344CCDD. LWR lo=1 on the same data: write 0xAA112233.
- Load captured with dc_rdata_valid in the same cycle (LW 0xDEADBEEF): write in the next cycle, no stall.
- wb_flush during WAIT_LOAD, data 2 cycles later: state DRAIN, no reg_write, wb_stall drops after data. The next instruction commits normally.
- rst_n low in WAIT_LOAD: next cycle EMPTY, all outputs 0, wb_stall 0.
